maquina_escritura_rtc: RTL and testbench
========================================

Name: maquina_escritura_rtc

Overview:
- Write-side sequencer for the RTC multiplexed address/data bus; the write counterpart of the RTC read sequencer.
- On a write request it snapshots the time/date values. It then presents one address byte and one data byte per register to the bus-timing controller, pacing each step on the controller's DIR/DAT/cambio_estado phase strobes.
- The final step issues the RAM-to-clock (or RAM-to-timer) transfer command, then reports completion to the main control FSM.

Parameters:
- ADDR_DIA, 8'h24, RTC address of day register
- ADDR_MES, 8'h25, RTC address of month register
- ADDR_ANO, 8'h26, RTC address of year register
- CMD_CLK, 8'hF1, command address: transfer RAM to clock
- CMD_TMR, 8'hF2, command address: transfer RAM to timer
- CMD_DATA, 8'h01, data byte written with either command
- IDLE_BYTE, 8'hFF, bus byte driven when idle

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Escritura  in  1  write request from main FSM (level, sampled in IDLE only)
- En_clk  in  1  1 = clock target (6 registers), 0 = timer target (3 registers)
- DIR  in  1  bus controller address phase strobe
- DAT  in  1  bus controller data phase strobe
- cambio_estado  in  1  bus controller end-of-transaction strobe
- D_Seg, D_Min, D_Hora  in  8 each  addresses of seconds/minutes/hours (clock or timer bank)
- Seg_E, Min_E, Hora_E, Dia_E, Mes_E, Ano_E  in  8 each  BCD values to write
- Dato_E  out  8  byte to bus (address during DIR, data during DAT)
- E_Esc  out  1  write-in-progress request to bus controller
- Term_Esc  out  1  one-cycle completion pulse
- Err_Esc  out  1  one-cycle abort pulse (optional feature only)

Behaviour:
- Reset: state IDLE, Dato_E=IDLE_BYTE, E_Esc=0, Term_Esc=0, Err_Esc=0, all snapshot registers 0, target flag 0. Reset mid-sequence abandons the sequence immediately; no completion pulse.
- All outputs are registered. Strobe effects appear on the outputs one clk after the strobe is sampled.
- States: IDLE, SEG, MIN, HORA, DIA, MES, ANO, CMD.
- IDLE:
  - Dato_E=IDLE_BYTE, E_Esc=0.
  - With Escritura=1: snapshot the six value inputs and En_clk into internal registers, set E_Esc=1, go to SEG.
  - Escritura is ignored in all other states.
- Each active state, evaluated every cycle with priority DIR > DAT > cambio_estado:
  - DIR=1: Dato_E <= state address.
  - DAT=1: Dato_E <= snapshot value.
  - cambio_estado=1: go to next state and drive E_Esc=0 for exactly one cycle.
  - Otherwise: hold the state, E_Esc=1, Dato_E unchanged.
- Addresses: SEG=D_Seg, MIN=D_Min, HORA=D_Hora (sampled live), DIA=ADDR_DIA, MES=ADDR_MES, ANO=ADDR_ANO, CMD=CMD_CLK if the snapshot target is clock, else CMD_TMR. CMD data byte = CMD_DATA.
- Sequence:
  - Clock target: SEG→MIN→HORA→DIA→MES→ANO→CMD→IDLE.
  - Timer target: SEG→MIN→HORA→CMD→IDLE, skipping DIA/MES/ANO with no bus activity.
- Completion: cambio_estado in CMD sets Term_Esc=1 for one cycle, coincident with entry to IDLE; Dato_E returns to IDLE_BYTE on the same edge.
- Re-arm: Escritura still high on the cycle after return to IDLE starts a new sequence with a fresh snapshot (back-to-back allowed).
- Simultaneous DIR and DAT: DIR wins. Strobes arriving in IDLE are ignored.
- Value inputs changing mid-sequence have no effect on the current sequence; the snapshot governs. Illegal state encodings recover to IDLE.

Optional Feature:
- Macro BCD_CHECK_EN.
- Defined: on the start cycle, each nibble of all applicable snapshot values is checked for ≤9 (DIA/MES/ANO only when En_clk=1).
  - Any invalid nibble: stay in IDLE, E_Esc stays 0, Err_Esc pulses 1 for one cycle, no bus activity.
  - All valid: normal start.
- Undefined: no check; Err_Esc tied 0.

Test Plan:
- Clock write: En_clk=1, D_Seg=21, D_Min=22, D_Hora=23, values 45/30/12/15/09/16; DIR/DAT/cambio_estado per step → Dato_E sequence 21,45,22,30,23,12,24,15,25,09,26,16,F1,01; single Term_Esc pulse; E_Esc low one cycle per step.
- Timer write: En_clk=0 → only SEG/MIN/HORA then F2,01; no 24/25/26 bytes; Term_Esc pulse.
- Snapshot: change Seg_E from 45 to 59 after start → DAT in SEG still drives 45.
- Reset asserted in MES → Dato_E=FF, E_Esc=0, no Term_Esc; new Escritura restarts at SEG.
- Priority/idle: DIR and DAT together in MIN → Dato_E=D_Min; strobes in IDLE → Dato_E stays FF.
- With BCD_CHECK_EN: Min_E=8'h6A → Err_Esc one pulse, E_Esc stays 0; without the macro, the same stimulus runs a normal write.

Source files
------------

// File: rtl/maquina_escritura_rtc.sv
// Write-side sequencer for the RTC multiplexed address/data bus.
// Snapshots the time/date values on a write request, then hands one address
// byte and one data byte per register to the bus-timing controller, paced by
// its DIR/DAT/cambio_estado strobes, and finishes with a RAM-to-clock or
// RAM-to-timer transfer command.
// Optional build macro: BCD_CHECK_EN (rejects non-BCD snapshots with Err_Esc).
module maquina_escritura_rtc #(
  parameter logic [7:0] ADDR_DIA  = 8'h24,
  parameter logic [7:0] ADDR_MES  = 8'h25,
  parameter logic [7:0] ADDR_ANO  = 8'h26,
  parameter logic [7:0] CMD_CLK   = 8'hF1,
  parameter logic [7:0] CMD_TMR   = 8'hF2,
  parameter logic [7:0] CMD_DATA  = 8'h01,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Escritura,
  input  logic       En_clk,
  input  logic       DIR,
  input  logic       DAT,
  input  logic       cambio_estado,
  input  logic [7:0] D_Seg,
  input  logic [7:0] D_Min,
  input  logic [7:0] D_Hora,
  input  logic [7:0] Seg_E,
  input  logic [7:0] Min_E,
  input  logic [7:0] Hora_E,
  input  logic [7:0] Dia_E,
  input  logic [7:0] Mes_E,
  input  logic [7:0] Ano_E,
  output logic [7:0] Dato_E,
  output logic       E_Esc,
  output logic       Term_Esc,
  output logic       Err_Esc
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEG  = 3'd1;
  localparam logic [2:0] MIN  = 3'd2;
  localparam logic [2:0] HORA = 3'd3;
  localparam logic [2:0] DIA  = 3'd4;
  localparam logic [2:0] MES  = 3'd5;
  localparam logic [2:0] ANO  = 3'd6;
  localparam logic [2:0] CMD  = 3'd7;

  logic [2:0] state, state_next;
  logic [7:0] seg_s, min_s, hora_s, dia_s, mes_s, ano_s;
  logic       target_clk;
  logic [7:0] dato_next;
  logic       e_esc_next, term_next;
  logic [7:0] step_addr, step_data;
  logic [2:0] step_next;
  logic       bcd_ok;
  logic       start;

`ifdef BCD_CHECK_EN
  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Date registers only matter when the clock bank is the target.
  assign bcd_ok = is_bcd(Seg_E) && is_bcd(Min_E) && is_bcd(Hora_E) &&
                  (!En_clk || (is_bcd(Dia_E) && is_bcd(Mes_E) && is_bcd(Ano_E)));

  // One-cycle abort pulse when a request is refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) Err_Esc <= 1'b0;
    else       Err_Esc <= (state == IDLE) && Escritura && !bcd_ok;
  end
`else
  assign bcd_ok  = 1'b1;
  assign Err_Esc = 1'b0;
`endif

  assign start = (state == IDLE) && Escritura && bcd_ok;

  // Per-state address, data byte and successor.
  always_comb begin
    step_addr = IDLE_BYTE;
    step_data = IDLE_BYTE;
    step_next = IDLE;
    case (state)
      SEG:  begin step_addr = D_Seg;    step_data = seg_s;  step_next = MIN;  end
      MIN:  begin step_addr = D_Min;    step_data = min_s;  step_next = HORA; end
      // Timer target has no date registers: jump straight to the command.
      HORA: begin
        step_addr = D_Hora;
        step_data = hora_s;
        step_next = target_clk ? DIA : CMD;
      end
      DIA:  begin step_addr = ADDR_DIA; step_data = dia_s;  step_next = MES;  end
      MES:  begin step_addr = ADDR_MES; step_data = mes_s;  step_next = ANO;  end
      ANO:  begin step_addr = ADDR_ANO; step_data = ano_s;  step_next = CMD;  end
      CMD:  begin
        step_addr = target_clk ? CMD_CLK : CMD_TMR;
        step_data = CMD_DATA;
        step_next = IDLE;
      end
      default: ;
    endcase
  end

  // Next-state and output decode; strobe priority DIR > DAT > cambio_estado.
  always_comb begin
    state_next = state;
    dato_next  = Dato_E;
    e_esc_next = E_Esc;
    term_next  = 1'b0;
    if (state == IDLE) begin
      dato_next  = IDLE_BYTE;
      e_esc_next = start;
      if (start) state_next = SEG;
    end else if (DIR) begin
      dato_next  = step_addr;
      e_esc_next = 1'b1;
    end else if (DAT) begin
      dato_next  = step_data;
      e_esc_next = 1'b1;
    end else if (cambio_estado) begin
      state_next = step_next;
      e_esc_next = 1'b0;
      if (state == CMD) begin
        dato_next = IDLE_BYTE;
        term_next = 1'b1;
      end
    end else begin
      e_esc_next = 1'b1;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      Dato_E   <= IDLE_BYTE;
      E_Esc    <= 1'b0;
      Term_Esc <= 1'b0;
    end else begin
      state    <= state_next;
      Dato_E   <= dato_next;
      E_Esc    <= e_esc_next;
      Term_Esc <= term_next;
    end
  end

  // Snapshot of the values and target, frozen for the whole sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s      <= 8'h00;
      min_s      <= 8'h00;
      hora_s     <= 8'h00;
      dia_s      <= 8'h00;
      mes_s      <= 8'h00;
      ano_s      <= 8'h00;
      target_clk <= 1'b0;
    end else if (start) begin
      seg_s      <= Seg_E;
      min_s      <= Min_E;
      hora_s     <= Hora_E;
      dia_s      <= Dia_E;
      mes_s      <= Mes_E;
      ano_s      <= Ano_E;
      target_clk <= En_clk;
    end
  end

endmodule

// File: tb/tb_maquina_escritura_rtc.sv
// Self-checking bench for maquina_escritura_rtc: expected bus bytes are
// queued when a strobe is driven and compared when the output updates.
module tb_maquina_escritura_rtc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Escritura = 1'b0, En_clk = 1'b0;
  logic       DIR = 1'b0, DAT = 1'b0, cambio_estado = 1'b0;
  logic [7:0] D_Seg = 8'h21, D_Min = 8'h22, D_Hora = 8'h23;
  logic [7:0] Seg_E = 8'h0, Min_E = 8'h0, Hora_E = 8'h0;
  logic [7:0] Dia_E = 8'h0, Mes_E = 8'h0, Ano_E = 8'h0;
  logic [7:0] Dato_E;
  logic       E_Esc, Term_Esc, Err_Esc;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  // Model snapshot, captured by the bench when it issues a request.
  logic [7:0] m_seg, m_min, m_hora, m_dia, m_mes, m_ano;

  maquina_escritura_rtc dut (
    .clk(clk), .reset(reset), .Escritura(Escritura), .En_clk(En_clk),
    .DIR(DIR), .DAT(DAT), .cambio_estado(cambio_estado),
    .D_Seg(D_Seg), .D_Min(D_Min), .D_Hora(D_Hora),
    .Seg_E(Seg_E), .Min_E(Min_E), .Hora_E(Hora_E),
    .Dia_E(Dia_E), .Mes_E(Mes_E), .Ano_E(Ano_E),
    .Dato_E(Dato_E), .E_Esc(E_Esc), .Term_Esc(Term_Esc), .Err_Esc(Err_Esc)
  );

  always #5 clk = ~clk;

  task automatic set_values(input logic [7:0] s, mi, h, d, me, a);
    Seg_E = s; Min_E = mi; Hora_E = h; Dia_E = d; Mes_E = me; Ano_E = a;
  endtask

  task automatic take_snapshot();
    m_seg = Seg_E; m_min = Min_E; m_hora = Hora_E;
    m_dia = Dia_E; m_mes = Mes_E; m_ano = Ano_E;
  endtask

  // Issue a request from IDLE; hold keeps Escritura high afterwards.
  task automatic start_write(input logic en, input logic hold);
    Escritura = 1'b1;
    En_clk = en;
    take_snapshot();
    @(negedge clk);
    if (!hold) Escritura = 1'b0;
    checks++;
    if (E_Esc !== 1'b1 || Dato_E !== 8'hFF) begin
      errors++;
      $display("FAIL start: E_Esc=%b Dato_E=%h required E_Esc=1 Dato_E=ff", E_Esc, Dato_E);
    end
  endtask

  // One register step: address, data, end-of-transaction.
  task automatic bus_step(input logic [7:0] addr, input logic [7:0] data,
                          input logic last, input logic rearm);
    DIR = 1'b1; sb.push_back(addr);
    @(negedge clk); DIR = 1'b0;
    exp_b = sb.pop_front(); checks++;
    if (Dato_E !== exp_b) begin
      errors++; $display("FAIL addr_byte: got %h required %h", Dato_E, exp_b);
    end
    DAT = 1'b1; sb.push_back(data);
    @(negedge clk); DAT = 1'b0;
    exp_b = sb.pop_front(); checks++;
    if (Dato_E !== exp_b) begin
      errors++; $display("FAIL data_byte: got %h required %h", Dato_E, exp_b);
    end
    cambio_estado = 1'b1;
    @(negedge clk); cambio_estado = 1'b0;
    checks++;
    if (E_Esc !== 1'b0 || Term_Esc !== last || (last && Dato_E !== 8'hFF)) begin
      errors++;
      $display("FAIL step_end: E_Esc=%b Term_Esc=%b Dato_E=%h required E_Esc=0 Term_Esc=%b",
               E_Esc, Term_Esc, Dato_E, last);
    end
    @(negedge clk);
    checks++;
    if (E_Esc !== (!last || rearm) || Term_Esc !== 1'b0) begin
      errors++;
      $display("FAIL after_step: E_Esc=%b Term_Esc=%b required E_Esc=%b Term_Esc=0",
               E_Esc, Term_Esc, (!last || rearm));
    end
  endtask

  task automatic do_steps(input logic en, input logic rearm);
    logic [7:0] a[7];
    logic [7:0] d[7];
    int n;
    if (en) begin
      a = '{D_Seg, D_Min, D_Hora, 8'h24, 8'h25, 8'h26, 8'hF1};
      d = '{m_seg, m_min, m_hora, m_dia, m_mes, m_ano, 8'h01};
      n = 7;
    end else begin
      a = '{D_Seg, D_Min, D_Hora, 8'hF2, 8'h00, 8'h00, 8'h00};
      d = '{m_seg, m_min, m_hora, 8'h01, 8'h00, 8'h00, 8'h00};
      n = 4;
    end
    for (int i = 0; i < n; i++) bus_step(a[i], d[i], i == n - 1, rearm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (Dato_E !== 8'hFF || E_Esc !== 1'b0 || Term_Esc !== 1'b0 || Err_Esc !== 1'b0) begin
      errors++;
      $display("FAIL reset: Dato_E=%h E_Esc=%b Term=%b Err=%b required ff/0/0/0",
               Dato_E, E_Esc, Term_Esc, Err_Esc);
    end
  endtask

  task automatic test_clock_write();
    set_values(8'h45, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
    start_write(1'b1, 1'b0);
    do_steps(1'b1, 1'b0);
  endtask

  task automatic test_timer_write();
    set_values(8'h07, 8'h08, 8'h19, 8'h31, 8'h12, 8'h99);
    start_write(1'b0, 1'b0);
    do_steps(1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    set_values(8'h45, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
    start_write(1'b0, 1'b0);
    Seg_E = 8'h59; Min_E = 8'h00;
    do_steps(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_values(8'h45, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16);
    start_write(1'b1, 1'b0);
    bus_step(D_Seg, m_seg, 1'b0, 1'b0);
    bus_step(D_Min, m_min, 1'b0, 1'b0);
    bus_step(D_Hora, m_hora, 1'b0, 1'b0);
    bus_step(8'h24, m_dia, 1'b0, 1'b0);
    DIR = 1'b1; sb.push_back(8'h25);
    @(negedge clk); DIR = 1'b0;
    exp_b = sb.pop_front(); checks++;
    if (Dato_E !== exp_b) begin
      errors++; $display("FAIL mes_addr: got %h required %h", Dato_E, exp_b);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (Dato_E !== 8'hFF || E_Esc !== 1'b0 || Term_Esc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: Dato_E=%h E_Esc=%b Term=%b required ff/0/0",
               Dato_E, E_Esc, Term_Esc);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (Term_Esc !== 1'b0 || E_Esc !== 1'b0) begin
      errors++; $display("FAIL reset_idle: Term=%b E_Esc=%b required 0/0", Term_Esc, E_Esc);
    end
    set_values(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    start_write(1'b1, 1'b0);
    do_steps(1'b1, 1'b0);
  endtask

  task automatic test_priority_idle();
    DIR = 1'b1; DAT = 1'b1; cambio_estado = 1'b1;
    repeat (2) @(negedge clk);
    DIR = 1'b0; DAT = 1'b0; cambio_estado = 1'b0;
    checks++;
    if (Dato_E !== 8'hFF || E_Esc !== 1'b0 || Term_Esc !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobes: Dato_E=%h E_Esc=%b Term=%b required ff/0/0",
               Dato_E, E_Esc, Term_Esc);
    end
    set_values(8'h33, 8'h44, 8'h21, 8'h00, 8'h00, 8'h00);
    start_write(1'b0, 1'b0);
    bus_step(D_Seg, m_seg, 1'b0, 1'b0);
    DIR = 1'b1; DAT = 1'b1; sb.push_back(D_Min);
    @(negedge clk); DIR = 1'b0; DAT = 1'b0;
    exp_b = sb.pop_front(); checks++;
    if (Dato_E !== exp_b) begin
      errors++; $display("FAIL dir_over_dat: got %h required %h", Dato_E, exp_b);
    end
    bus_step(D_Min, m_min, 1'b0, 1'b0);
    bus_step(D_Hora, m_hora, 1'b0, 1'b0);
    bus_step(8'hF2, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_values(8'h11, 8'h12, 8'h13, 8'h00, 8'h00, 8'h00);
    start_write(1'b0, 1'b1);
    set_values(8'h54, 8'h55, 8'h22, 8'h00, 8'h00, 8'h00);
    do_steps(1'b0, 1'b1);
    Escritura = 1'b0;
    take_snapshot();
    do_steps(1'b0, 1'b0);
  endtask

  task automatic test_bcd();
    set_values(8'h45, 8'h6A, 8'h12, 8'h15, 8'h09, 8'h16);
`ifdef BCD_CHECK_EN
    Escritura = 1'b1; En_clk = 1'b0;
    @(negedge clk); Escritura = 1'b0;
    checks++;
    if (Err_Esc !== 1'b1 || E_Esc !== 1'b0 || Dato_E !== 8'hFF) begin
      errors++;
      $display("FAIL bcd_err: Err=%b E_Esc=%b Dato_E=%h required 1/0/ff", Err_Esc, E_Esc, Dato_E);
    end
    @(negedge clk);
    checks++;
    if (Err_Esc !== 1'b0 || E_Esc !== 1'b0) begin
      errors++; $display("FAIL bcd_pulse: Err=%b E_Esc=%b required 0/0", Err_Esc, E_Esc);
    end
`else
    start_write(1'b0, 1'b0);
    checks++;
    if (Err_Esc !== 1'b0) begin
      errors++; $display("FAIL no_bcd_err: Err=%b required 0", Err_Esc);
    end
    do_steps(1'b0, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_clock_write();
    test_timer_write();
    test_snapshot();
    test_reset_mid();
    test_priority_idle();
    test_back_to_back();
    test_bcd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
